// File: rtl/avg_speed_engine.sv
// Trip average-speed engine: latches distance/time, runs one shared-divider
// division, then saturates and registers the result in tenths of km/h or mph.
// Optional max-speed tracking is built when AVG_SPEED_MAX_TRACK_EN is defined.
module avg_speed_engine #(
  parameter int DIST_W      = 16,
  parameter int TIME_W      = 16,
  parameter int DIV_W       = 32,
  parameter int OUT_W       = 10,
  parameter int SAT_MAX     = 999,
  parameter int MIN_TIME    = 5,
  parameter int REFRESH_CYC = 1000000,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              unit_mph,
  input  logic [DIST_W-1:0] trip_dist,
  input  logic [TIME_W-1:0] trip_time,
  input  logic              div_busy,
  input  logic              div_ready,
  input  logic [DIV_W-1:0]  div_quot,
  output logic              div_start,
  output logic [DIV_W-1:0]  div_dividend,
  output logic [DIV_W-1:0]  div_divisor,
  output logic [OUT_W-1:0]  avg_speed,
  output logic              valid,
  output logic              sat,
  output logic              err_timeout,
  output logic [OUT_W-1:0]  max_speed
);

  // Divider handshake: div_start is a 1-cycle pulse issued only after div_busy
  // was seen low; the divider acknowledges by raising div_busy and delivers the
  // quotient with a 1-cycle div_ready pulse. state_q is the observable FSM state.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WAIT_RES = 3'd4
  } state_t;

  localparam int RC_W    = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int RC_LAST = (REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0;
  localparam bit RC_EN   = (REFRESH_CYC > 0);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              mph_q, mph_d;
  logic              div_start_q, div_start_d;
  logic [DIV_W-1:0]  dividend_q, dividend_d;
  logic [DIV_W-1:0]  divisor_q, divisor_d;
  logic [OUT_W-1:0]  avg_q, avg_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;

  logic              ref_hit;
  logic              to_hit;
  logic              res_sat;
  logic [OUT_W-1:0]  res_val;
  logic [DIV_W-1:0]  dist_ext, time_ext, dvd_kmh, dvd_mph, dvs_mph;

  assign ref_hit  = RC_EN && (ref_cnt_q == RC_W'(RC_LAST));
  assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign res_sat  = (div_quot > DIV_W'(SAT_MAX));
  assign res_val  = res_sat ? OUT_W'(SAT_MAX) : div_quot[OUT_W-1:0];

  // mph scaling: 3.6 / 1.609344 ~= 5727/2560, so time is pre-shifted by 8.
  assign dist_ext = DIV_W'(dist_q);
  assign time_ext = DIV_W'(time_q);
  assign dvd_kmh  = dist_ext * DIV_W'(36);
  assign dvd_mph  = dist_ext * DIV_W'(5727);
  assign dvs_mph  = time_ext << 8;

  always_comb begin
    state_d     = state_q;
    ref_cnt_d   = ref_cnt_q;
    to_cnt_d    = to_cnt_q;
    dist_d      = dist_q;
    time_d      = time_q;
    mph_d       = mph_q;
    div_start_d = 1'b0;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    avg_d       = avg_q;
    valid_d     = valid_q;
    sat_d       = sat_q;
    err_d       = err_q;
    if (!en) begin
      div_start_d = div_start_q;
      valid_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start || ref_hit) begin
            state_d   = S_LATCH;
            valid_d   = 1'b0;
            ref_cnt_d = '0;
          end else if (RC_EN) begin
            ref_cnt_d = ref_cnt_q + 1'b1;
          end
        end
        S_LATCH: begin
          dist_d = trip_dist;
          time_d = trip_time;
          mph_d  = unit_mph;
          if (trip_time < TIME_W'(MIN_TIME)) begin
            avg_d   = '0;
            sat_d   = 1'b0;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_cnt_d = '0;
            state_d  = S_REQ;
          end
        end
        S_REQ: begin
          if (!div_busy) begin
            div_start_d = 1'b1;
            dividend_d  = mph_q ? dvd_mph : dvd_kmh;
            divisor_d   = mph_q ? dvs_mph : time_ext;
            to_cnt_d    = '0;
            state_d     = S_WAIT_ACK;
          end else if (to_hit) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (div_busy) begin
            to_cnt_d = '0;
            state_d  = S_WAIT_RES;
          end else if (to_hit) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        S_WAIT_RES: begin
          if (div_ready) begin
            avg_d   = res_val;
            sat_d   = res_sat;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else if (to_hit) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ref_cnt_q   <= '0;
      to_cnt_q    <= '0;
      dist_q      <= '0;
      time_q      <= '0;
      mph_q       <= 1'b0;
      div_start_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      avg_q       <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      to_cnt_q    <= to_cnt_d;
      dist_q      <= dist_d;
      time_q      <= time_d;
      mph_q       <= mph_d;
      div_start_q <= div_start_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      avg_q       <= avg_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
    end
  end

  assign div_start    = div_start_q & en;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign avg_speed    = avg_q;
  assign valid        = valid_q & en;
  assign sat          = sat_q;
  assign err_timeout  = err_q;

`ifdef AVG_SPEED_MAX_TRACK_EN
  logic [OUT_W-1:0] max_q, max_d;

  // Only divider results count; the short-trip zero result never raises the max.
  always_comb begin
    max_d = max_q;
    if (en && (state_q == S_WAIT_RES) && div_ready && (res_val > max_q)) max_d = res_val;
  end

  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

  assign max_speed = max_q;
`else
  assign max_speed = '0;
`endif

endmodule

// File: tb/tb_avg_speed_engine.sv
// Bench for avg_speed_engine: divider responder, directed + random stimulus,
// queue scoreboard fed from an arithmetic reference model, and a refresh instance.
module tb_avg_speed_engine;
  localparam int DIST_W   = 16;
  localparam int TIME_W   = 16;
  localparam int DIV_W    = 32;
  localparam int OUT_W    = 10;
  localparam int SAT_MAX  = 999;
  localparam int MIN_TIME = 5;
  localparam int TIMEOUT  = 16;
  localparam int EW       = 2 * OUT_W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              en, start, unit_mph;
  logic [DIST_W-1:0] trip_dist;
  logic [TIME_W-1:0] trip_time;
  logic              div_busy, div_ready;
  logic [DIV_W-1:0]  div_quot;
  logic              div_start;
  logic [DIV_W-1:0]  div_dividend, div_divisor;
  logic [OUT_W-1:0]  avg_speed, max_speed;
  logic              valid, sat, err_timeout;

  avg_speed_engine #(
    .DIST_W(DIST_W), .TIME_W(TIME_W), .DIV_W(DIV_W), .OUT_W(OUT_W),
    .SAT_MAX(SAT_MAX), .MIN_TIME(MIN_TIME), .REFRESH_CYC(0), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .unit_mph(unit_mph),
    .trip_dist(trip_dist), .trip_time(trip_time),
    .div_busy(div_busy), .div_ready(div_ready), .div_quot(div_quot),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .avg_speed(avg_speed), .valid(valid), .sat(sat), .err_timeout(err_timeout),
    .max_speed(max_speed)
  );

  // refresh-only instance: start tied low, fixed inputs
  logic              r_busy, r_ready, r_start, r_valid, r_sat, r_err;
  logic [DIV_W-1:0]  r_quot, r_dividend, r_divisor, r_qp;
  logic [OUT_W-1:0]  r_avg, r_max;
  logic [DIST_W-1:0] r_dist;
  logic [TIME_W-1:0] r_time;
  assign r_dist = DIST_W'(500);
  assign r_time = TIME_W'(100);

  avg_speed_engine #(
    .DIST_W(DIST_W), .TIME_W(TIME_W), .DIV_W(DIV_W), .OUT_W(OUT_W),
    .SAT_MAX(SAT_MAX), .MIN_TIME(MIN_TIME), .REFRESH_CYC(50), .TIMEOUT(TIMEOUT)
  ) u_ref (
    .clk(clk), .rst(rst), .en(1'b1), .start(1'b0), .unit_mph(1'b0),
    .trip_dist(r_dist), .trip_time(r_time),
    .div_busy(r_busy), .div_ready(r_ready), .div_quot(r_quot),
    .div_start(r_start), .div_dividend(r_dividend), .div_divisor(r_divisor),
    .avg_speed(r_avg), .valid(r_valid), .sat(r_sat), .err_timeout(r_err),
    .max_speed(r_max)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // divider responder for the main DUT
  logic             int_busy, ext_busy, div_mute;
  logic [DIV_W-1:0] q_pend;
  int               lat_left;
  assign div_busy = int_busy | ext_busy;

  initial begin
    int_busy = 1'b0; div_ready = 1'b0; div_quot = '0; lat_left = 0; q_pend = '0;
    forever begin
      @(negedge clk);
      div_ready = 1'b0;
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          int_busy = 1'b0; div_ready = 1'b1; div_quot = q_pend;
        end
      end else if (div_start && !div_mute) begin
        int_busy = 1'b1;
        lat_left = $urandom_range(2, 8);
        q_pend   = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
      end
    end
  end

  // divider responder for the refresh instance
  int r_left;
  initial begin
    r_busy = 1'b0; r_ready = 1'b0; r_quot = '0; r_left = 0; r_qp = '0;
    forever begin
      @(negedge clk);
      r_ready = 1'b0;
      if (r_left > 0) begin
        r_left--;
        if (r_left == 0) begin
          r_busy = 1'b0; r_ready = 1'b1; r_quot = r_qp;
        end
      end else if (r_start) begin
        r_busy = 1'b1; r_left = 3;
        r_qp   = (r_divisor == '0) ? '1 : r_dividend / r_divisor;
      end
    end
  end

  // scoreboard
  logic [EW-1:0]      exp_q[$];
  logic [2*DIV_W-1:0] op_q[$];
  logic [OUT_W-1:0]   exp_max = '0;

  initial begin : monitor
    logic          valid_prev;
    logic [EW-1:0] e;
    logic [2*DIV_W-1:0] op;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        if (op_q.size() == 0) check("div_start_unexpected", div_start, 0);
        else begin
          op = op_q.pop_front();
          check("dividend", div_dividend, op[2*DIV_W-1:DIV_W]);
          check("divisor", div_divisor, op[DIV_W-1:0]);
        end
      end
      if (valid && !valid_prev) begin
        if (exp_q.size() == 0) check("valid_unexpected", valid, 0);
        else begin
          e = exp_q.pop_front();
          check("avg_speed", avg_speed, e[OUT_W-1:0]);
          check("sat", sat, e[OUT_W]);
          check("max_speed", max_speed, e[EW-1:OUT_W+1]);
        end
      end
      valid_prev = valid;
    end
  end

  int r_starts = 0;
  initial begin : ref_monitor
    int cyc, last_start;
    logic rv_prev;
    cyc = 0; last_start = -1; rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) last_start = -1;
      else begin
        if (r_start) begin
          r_starts++;
          if (last_start >= 0)
            check("refresh_period_in_range", ((cyc - last_start) >= 50 && (cyc - last_start) <= 70), 1);
          last_start = cyc;
        end
        if (r_valid && !rv_prev) check("refresh_avg", r_avg, 180);
      end
      rv_prev = r_valid;
    end
  end

  // driver tasks
  task automatic issue(input int unsigned d, input int unsigned t, input bit u, input bit expres);
    longint unsigned dvd, dvs, q;
    logic [OUT_W-1:0] a, em;
    logic s;
    longint unsigned ld, lt;
    ld = d; lt = t;
    trip_dist = DIST_W'(d); trip_time = TIME_W'(t); unit_mph = u;
    a = '0; s = 1'b0;
    if (t >= MIN_TIME) begin
      dvd = u ? ld * 5727 : ld * 36;
      dvs = u ? lt * 256 : lt;
      q   = dvd / dvs;
      op_q.push_back({dvd[DIV_W-1:0], dvs[DIV_W-1:0]});
      if (q > SAT_MAX) begin a = OUT_W'(SAT_MAX); s = 1'b1; end
      else a = q[OUT_W-1:0];
      if (expres && a > exp_max) exp_max = a;
    end
`ifdef AVG_SPEED_MAX_TRACK_EN
    em = exp_max;
`else
    em = '0;
`endif
    if (expres) exp_q.push_back({em, s, a});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input int unsigned d, input int unsigned t, input bit u);
    issue(d, t, u, 1'b1);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned d, t;
    int r, n;
    en = 1'b1; start = 1'b0; unit_mph = 1'b0; trip_dist = '0; trip_time = '0;
    ext_busy = 1'b0; div_mute = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_avg", avg_speed, 0);
    check("rst_valid", valid, 0);
    check("rst_sat", sat, 0);
    check("rst_err", err_timeout, 0);
    check("rst_div_start", div_start, 0);
    check("rst_dividend", div_dividend, 0);
    check("rst_max", max_speed, 0);
    rst = 1'b0;
    @(negedge clk);

    run(1000, 360, 0);
    run(1000, 360, 1);
    run(10000, 10, 0);
    run(999, 36, 0);
    run(1000, 36, 0);
    run(0, 5, 0);
    run(1234, MIN_TIME - 1, 0);
    run(65535, 65535, 1);

    // short-trip latency: valid low in LATCH, high the cycle after
    issue(800, 3, 0, 1'b1);
    check("min_latch_valid", valid, 0);
    @(negedge clk);
    check("min_valid", valid, 1);
    check("min_avg", avg_speed, 0);
    wait_done();

    // divider held busy by another master
    ext_busy = 1'b1;
    issue(3000, 200, 1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("req_hold_no_start", div_start, 0);
      @(negedge clk);
    end
    ext_busy = 1'b0;
    wait_done();

    // enable low freezes while latching
    issue(4321, 777, 0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("en_low_valid", valid, 0);
      check("en_low_start", div_start, 0);
      @(negedge clk);
    end
    en = 1'b1;
    wait_done();

    // divider never acknowledges
    div_mute = 1'b1;
    issue(2000, 100, 0, 1'b0);
    repeat (8) @(negedge clk);
    check("tmo_err_early", err_timeout, 0);
    repeat (30) @(negedge clk);
    check("tmo_err", err_timeout, 1);
    check("tmo_valid", valid, 0);
    div_mute = 1'b0;
    run(1000, 360, 0);
    check("tmo_err_sticky", err_timeout, 1);

    // reset during WAIT_RES, late div_ready must be ignored
    issue(5000, 400, 0, 1'b1);
    n = 0;
    while (!int_busy && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    exp_q.delete();
    op_q.delete();
    rst = 1'b1;
    exp_max = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_avg", avg_speed, 0);
    check("post_rst_valid", valid, 0);
    check("post_rst_sat", sat, 0);
    check("post_rst_err", err_timeout, 0);
    check("post_rst_max", max_speed, 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      t = $urandom_range(0, 6);
      else if (r < 5)  t = $urandom_range(5, 400);
      else             t = $urandom_range(5, 65535);
      d = $urandom_range(0, 65535);
      run(d, t, 1'($urandom_range(0, 1)));
    end

    check("refresh_seen", (r_starts >= 3), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
